mips_run_monitor: RTL and testbench

MIPS_RUN_MONITOR -- requirements
Module: mips_run_monitor

---
 rtl/mips_run_monitor.sv | 131 +++++++++++++
 tb/tb_mips_run_monitor.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_monitor.sv
// Run monitor for a MIPS core under test: detects the start of a program run at the
// reset vector, gathers cycle/fetch/redirect statistics, and latches a pass/fail
// verdict when the program halts or overruns its cycle budget.
module mips_run_monitor #(
  parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR      = 32'h00000000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        clk_enable_i,
  input  logic        active_i,
  input  logic [31:0] instr_address_i,
  input  logic [31:0] register_v0_i,
  input  logic [31:0] expected_v0_i,
  output logic [1:0]  state_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic [31:0] cycle_count_o,
  output logic [31:0] fetch_count_o,
  output logic [31:0] redirect_count_o,
  output logic [31:0] final_v0_o
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalted  = 2'd2,
    StTimeout = 2'd3
  } state_e;

  // Pre-increment cycle count on the edge that exhausts the budget.
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] redirect_q, redirect_d;
  logic [31:0] prev_addr_q, prev_addr_d;
  logic [31:0] final_v0_q, final_v0_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        halt;
  logic        v0_match;

  assign halt     = (instr_address_i == HALT_ADDR) || !active_i;
  assign v0_match = (register_v0_i == expected_v0_i);

  // Next-state: start on reset-vector fetch, accumulate statistics, resolve verdict.
  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    fetch_d     = fetch_q;
    redirect_d  = redirect_q;
    prev_addr_d = prev_addr_q;
    final_v0_d  = final_v0_q;
    pass_d      = pass_q;
    fail_d      = fail_q;
    if (clk_enable_i) begin
      case (state_q)
        StIdle: begin
          if (instr_address_i == RESET_VECTOR) begin
            state_d     = StRun;
            cycle_d     = 32'd1;
            fetch_d     = 32'd1;
            redirect_d  = 32'd0;
            prev_addr_d = instr_address_i;
          end
        end
        StRun: begin
          cycle_d = (cycle_q == 32'hFFFFFFFF) ? cycle_q : cycle_q + 32'd1;
          // A stalled PC is not a new fetch; a non-sequential move is a redirect.
          if (instr_address_i != prev_addr_q) begin
            fetch_d = fetch_q + 32'd1;
            if (instr_address_i != prev_addr_q + 32'd4) begin
              redirect_d = redirect_q + 32'd1;
            end
          end
          prev_addr_d = instr_address_i;
          // Halt takes priority over a coincident timeout.
          if (halt) begin
            state_d    = StHalted;
            final_v0_d = register_v0_i;
            pass_d     = v0_match;
            fail_d     = !v0_match;
          end else if (cycle_q == TimeoutLast) begin
            state_d    = StTimeout;
            final_v0_d = register_v0_i;
            pass_d     = 1'b0;
            fail_d     = 1'b1;
          end
        end
        default: ;  // HALTED and TIMEOUT hold until reset
      endcase
    end
  end

  // State and statistics registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      cycle_q     <= 32'd0;
      fetch_q     <= 32'd0;
      redirect_q  <= 32'd0;
      prev_addr_q <= 32'd0;
      final_v0_q  <= 32'd0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      fetch_q     <= fetch_d;
      redirect_q  <= redirect_d;
      prev_addr_q <= prev_addr_d;
      final_v0_q  <= final_v0_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
    end
  end

  assign state_o          = state_q;
  assign done_o           = (state_q == StHalted) || (state_q == StTimeout);
  assign pass_o           = pass_q;
  assign fail_o           = fail_q;
  assign cycle_count_o    = cycle_q;
  assign fetch_count_o    = fetch_q;
  assign redirect_count_o = redirect_q;
  assign final_v0_o       = final_v0_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: a trace-based model compared every cycle, plus
// hand-computed literal expectations for the directed run scenarios.
module tb_mips_run_monitor;

  localparam logic [31:0] RV   = 32'hBFC00000;
  localparam logic [31:0] HALT = 32'h00000000;
  localparam int          TO   = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clk_enable;
  logic        active;
  logic [31:0] instr_address;
  logic [31:0] register_v0;
  logic [31:0] expected_v0;
  logic [1:0]  state;
  logic        done, pass, fail;
  logic [31:0] cycle_count, fetch_count, redirect_count, final_v0;

  mips_run_monitor #(
    .RESET_VECTOR  (RV),
    .HALT_ADDR     (HALT),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i           (clk),
    .reset_ni        (reset_n),
    .clk_enable_i    (clk_enable),
    .active_i        (active),
    .instr_address_i (instr_address),
    .register_v0_i   (register_v0),
    .expected_v0_i   (expected_v0),
    .state_o         (state),
    .done_o          (done),
    .pass_o          (pass),
    .fail_o          (fail),
    .cycle_count_o   (cycle_count),
    .fetch_count_o   (fetch_count),
    .redirect_count_o(redirect_count),
    .final_v0_o      (final_v0)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the run is the list of addresses seen on enabled edges since the start.
  logic [31:0] trace[$];
  logic [1:0]  m_st;
  logic [31:0] m_final;
  logic        m_pass, m_fail;

  function automatic logic [31:0] m_fetch();
    logic [31:0] n;
    if (trace.size() == 0) return 32'd0;
    n = 32'd1;
    for (int i = 1; i < trace.size(); i++) if (trace[i] != trace[i-1]) n++;
    return n;
  endfunction

  function automatic logic [31:0] m_redirect();
    logic [31:0] n;
    n = 32'd0;
    for (int i = 1; i < trace.size(); i++)
      if (trace[i] != trace[i-1] && trace[i] != trace[i-1] + 32'd4) n++;
    return n;
  endfunction

  task automatic model_clear();
    trace.delete();
    m_st    = 2'd0;
    m_final = 32'd0;
    m_pass  = 1'b0;
    m_fail  = 1'b0;
  endtask

  task automatic model_edge(input logic en, input logic [31:0] a, input logic act,
                            input logic [31:0] v0, input logic [31:0] exp);
    if (!en) return;
    if (m_st == 2'd0) begin
      if (a == RV) begin
        trace.push_back(a);
        m_st = 2'd1;
      end
    end else if (m_st == 2'd1) begin
      trace.push_back(a);
      if (a == HALT || !act) begin
        m_st = 2'd2; m_final = v0; m_pass = (v0 == exp); m_fail = (v0 != exp);
      end else if (trace.size() == TO) begin
        m_st = 2'd3; m_final = v0; m_pass = 1'b0; m_fail = 1'b1;
      end
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state", 32'(state), 32'(m_st));
      chk("done", 32'(done), 32'(m_st >= 2'd2));
      chk("pass", 32'(pass), 32'(m_pass));
      chk("fail", 32'(fail), 32'(m_fail));
      chk("cycle_count", cycle_count, 32'(trace.size()));
      chk("fetch_count", fetch_count, m_fetch());
      chk("redirect_count", redirect_count, m_redirect());
      chk("final_v0", final_v0, m_final);
    end
  end

  task automatic step(input logic en, input logic [31:0] a, input logic act,
                      input logic [31:0] v0);
    @(negedge clk);
    clk_enable    = en;
    instr_address = a;
    active        = act;
    register_v0   = v0;
    @(posedge clk);
    model_edge(en, a, act, v0, expected_v0);
    #2;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_flags"}, 32'({done, pass, fail}), 32'd0);
    chk({tag, "_cycle"}, cycle_count, 32'd0);
    chk({tag, "_fetch"}, fetch_count, 32'd0);
    chk({tag, "_redirect"}, redirect_count, 32'd0);
    chk({tag, "_final"}, final_v0, 32'd0);
  endtask

  // Reset pulsed between edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_zero(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_030(input logic [31:0] v0);
    step(1'b1, RV, 1'b1, v0);
    step(1'b1, RV + 32'h4, 1'b1, v0);
    step(1'b1, RV + 32'hC, 1'b1, v0);
    step(1'b1, RV + 32'h10, 1'b1, v0);
    step(1'b1, RV + 32'h14, 1'b1, v0);
    step(1'b1, HALT, 1'b1, v0);
  endtask

  initial begin
    reset_n       = 1'b0;
    clk_enable    = 1'b0;
    active        = 1'b1;
    instr_address = 32'd0;
    register_v0   = 32'd0;
    expected_v0   = 32'd0;
    model_clear();
    #3;
    check_zero("por");
    @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;

    // Non-vector addresses leave the monitor idle.
    step(1'b1, 32'h00001234, 1'b1, 0);
    step(1'b1, RV + 32'h4, 1'b1, 0);
    chk("idle_state", 32'(state), 32'd0);
    chk("idle_cycle", cycle_count, 32'd0);

    // Matching $v0 -> pass.
    expected_v0 = 32'd64;
    run_030(32'd64);
    chk("p_state", 32'(state), 32'd2);
    chk("p_pass", 32'(pass), 32'd1);
    chk("p_fail", 32'(fail), 32'd0);
    chk("p_cycle", cycle_count, 32'd6);
    chk("p_fetch", fetch_count, 32'd6);
    chk("p_redirect", redirect_count, 32'd2);
    chk("p_final", final_v0, 32'd64);
    // Terminal: later activity changes nothing.
    step(1'b1, RV, 1'b0, 32'd99);
    step(1'b1, RV + 32'h8, 1'b1, 32'd99);
    chk("term_cycle", cycle_count, 32'd6);
    chk("term_final", final_v0, 32'd64);
    do_reset("r1");

    // Mismatching $v0 -> fail.
    expected_v0 = 32'd65;
    run_030(32'd64);
    chk("f_state", 32'(state), 32'd2);
    chk("f_fail", 32'(fail), 32'd1);
    chk("f_pass", 32'(pass), 32'd0);
    chk("f_final", final_v0, 32'd64);
    do_reset("r2");

    // Endless two-instruction loop -> timeout after TO edges.
    for (int i = 0; i < 12; i++) step(1'b1, (i % 2 == 0) ? RV : RV + 32'h4, 1'b1, 32'd5);
    chk("t_state", 32'(state), 32'd3);
    chk("t_cycle", cycle_count, 32'd8);
    chk("t_fail", 32'(fail), 32'd1);
    chk("t_pass", 32'(pass), 32'd0);
    chk("t_redirect", redirect_count, 32'd3);
    do_reset("r3");

    // Enable low mid-run with PC moving; then a reset-vector fetch is ordinary.
    expected_v0 = 32'd7;
    step(1'b1, RV, 1'b1, 32'd7);
    step(1'b1, RV + 32'h4, 1'b1, 32'd7);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h40 + 32'(4 * i), 1'b0, 32'd7);
    chk("en_state", 32'(state), 32'd1);
    chk("en_cycle", cycle_count, 32'd2);
    chk("en_fetch", fetch_count, 32'd2);
    step(1'b1, RV, 1'b1, 32'd7);
    chk("rv_state", 32'(state), 32'd1);
    chk("rv_cycle", cycle_count, 32'd3);
    chk("rv_redirect", redirect_count, 32'd1);
    step(1'b1, HALT, 1'b1, 32'd7);
    chk("rv_pass", 32'(pass), 32'd1);
    do_reset("r4");

    // Stalled PC then active drop.
    expected_v0 = 32'd1;
    step(1'b1, RV, 1'b1, 32'd1);
    step(1'b1, RV + 32'h4, 1'b1, 32'd1);
    step(1'b1, RV + 32'h8, 1'b1, 32'd1);
    step(1'b1, RV + 32'h8, 1'b1, 32'd1);
    step(1'b1, RV + 32'h8, 1'b1, 32'd1);
    step(1'b1, RV + 32'h8, 1'b0, 32'd1);
    chk("s_state", 32'(state), 32'd2);
    chk("s_cycle", cycle_count, 32'd6);
    chk("s_fetch", fetch_count, 32'd3);
    chk("s_redirect", redirect_count, 32'd0);
    do_reset("r5");

    // Reset mid-run abandons the run; restart needs the reset vector again.
    step(1'b1, RV, 1'b1, 32'd0);
    step(1'b1, RV + 32'h4, 1'b1, 32'd0);
    do_reset("mid");
    step(1'b1, RV + 32'h8, 1'b1, 32'd0);
    chk("mid_idle", 32'(state), 32'd0);
    step(1'b1, RV, 1'b1, 32'd0);
    chk("re_state", 32'(state), 32'd1);
    chk("re_cycle", cycle_count, 32'd1);
    chk("re_fetch", fetch_count, 32'd1);

    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
